mem_txn_scheduler: RTL and testbench

Single-outstanding memory transaction scheduler that shares one memory port among N cache requesters in the multi-core system. Sits between the per-core caches and the shared memory. Grants requesters round-robin and sequences each transaction through issue, wait and respond phases. Routes the response back to the granted requester, and reports a timed-out read as an error.

---
 rtl/mem_txn_scheduler.sv | 166 ++++++++++++++++
 tb/tb_mem_txn_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_txn_scheduler.sv
// Round-robin scheduler sharing one memory port among N requesters with a
// single outstanding transaction sequenced through IDLE/ISSUE/WAIT/RESP.
module mem_txn_scheduler #(
    parameter int unsigned N       = 3,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lat_we_q, lat_we_d;
    logic [AW-1:0]   lat_addr_q, lat_addr_d;
    logic [DW-1:0]   lat_wdata_q, lat_wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   scan_idx;

    // N is not necessarily a power of two, so the wrap is an explicit compare
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (32'(v) == N - 1) ? '0 : v + IW'(1);
    endfunction

    // First valid requester at or above rr_ptr, modulo N
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = rr_ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_idx_d   = sel_idx;
                    lat_we_d    = req_we[sel_idx];
                    lat_addr_d  = req_addr[32'(sel_idx) * AW +: AW];
                    lat_wdata_d = req_wdata[32'(sel_idx) * DW +: DW];
                    err_d       = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    if (lat_we_q) begin
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // Read data arriving on the timeout cycle takes priority
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end else if (32'(tmo_cnt_q) == TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rr_ptr_d = wrap_inc(gnt_idx_q);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Outputs decode registered state; req_ready also follows the live scan
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == S_IDLE && sel_found && !reset) begin
            req_ready[sel_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            resp_valid[gnt_idx_q] = 1'b1;
        end
    end

    assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign mem_req    = (state_q == S_ISSUE);
    assign mem_we     = (state_q == S_ISSUE) && lat_we_q;
    assign mem_addr   = (state_q == S_ISSUE) ? lat_addr_q : '0;
    assign mem_wdata  = (state_q == S_ISSUE) ? lat_wdata_q : '0;

endmodule

// File: tb/tb_mem_txn_scheduler.sv
// Self-checking bench for mem_txn_scheduler: directed scenarios plus random
// transactions checked against a transaction-level round-robin/latency model.
module tb_mem_txn_scheduler;

    localparam int unsigned N   = 3;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    mem_txn_scheduler #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned     pass_cnt = 0;
    int unsigned     chk_cnt  = 0;
    int              rr_m     = 0;
    logic [AW-1:0]   addr_v [N];
    logic [DW-1:0]   data_v [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic drive_payload(input logic [N-1:0] vmask, input logic [N-1:0] wemask);
        req_valid = vmask;
        req_we    = wemask;
        for (int i = 0; i < int'(N); i++) begin
            req_addr[i*AW +: AW]  = addr_v[i];
            req_wdata[i*DW +: DW] = data_v[i];
        end
    endtask

    // Reference arbitration: first valid index scanning upward from rr_m
    function automatic int pick(input logic [N-1:0] vmask);
        for (int k = 0; k < int'(N); k++) begin
            if (vmask[(rr_m + k) % int'(N)]) return (rr_m + k) % int'(N);
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_resp"},  resp_valid, 0);
        chk({tag, "_rdata"}, resp_rdata, 0);
        chk({tag, "_err"},   resp_err, 0);
        chk({tag, "_mreq"},  mem_req, 0);
        chk({tag, "_mwe"},   mem_we, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdat"}, mem_wdata, 0);
    endtask

    // One transaction starting in an IDLE cycle; gd = gnt stall cycles,
    // rd = WAIT cycles before rvalid (rd >= TMO never answers)
    task automatic run_txn(input logic [N-1:0] vmask, input logic [N-1:0] wemask,
                           input int gd, input int rd, input logic [DW-1:0] rdata,
                           input bit noise);
        int            w;
        bit            wr;
        bit            err;
        logic [N-1:0]  exp_one;
        logic [DW-1:0] exp_data;
        w        = pick(vmask);
        wr       = wemask[w];
        exp_one  = '0;
        exp_one[w] = 1'b1;
        err      = !wr && (rd >= int'(TMO));
        exp_data = (wr || err) ? '0 : rdata;
        drive_payload(vmask, wemask);
        @(negedge clk);
        chk("accept_ready", req_ready, exp_one);
        chk("accept_mreq", mem_req, 0);
        @(posedge clk); #1;
        for (int g = 0; g <= gd; g++) begin
            mem_gnt = (g == gd);
            if (noise) req_valid = N'($urandom);
            @(negedge clk);
            chk("issue_mreq", mem_req, 1);
            chk("issue_addr", mem_addr, addr_v[w]);
            chk("issue_wdata", mem_wdata, data_v[w]);
            chk("issue_we", mem_we, wr);
            chk("issue_ready", req_ready, 0);
            @(posedge clk); #1;
            mem_gnt = 1'b0;
        end
        if (!wr) begin
            for (int t = 0; t < int'(TMO); t++) begin
                mem_rvalid = (t == rd);
                mem_rdata  = (t == rd) ? rdata : DW'($urandom);
                @(negedge clk);
                chk("wait_mreq", mem_req, 0);
                chk("wait_resp", resp_valid, 0);
                chk("wait_ready", req_ready, 0);
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                if (t == rd) break;
            end
        end
        mem_rvalid = 1'b1;
        mem_gnt    = 1'b1;
        mem_rdata  = DW'($urandom);
        @(negedge clk);
        chk("resp_valid", resp_valid, exp_one);
        chk("resp_rdata", resp_rdata, exp_data);
        chk("resp_err", resp_err, err);
        chk("resp_mreq", mem_req, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        rr_m       = (w + 1) % int'(N);
    endtask

    // IDLE cycle with no requests and stray memory strobes that must be ignored
    task automatic idle_check();
        req_valid  = '0;
        mem_rvalid = 1'b1;
        mem_gnt    = 1'b1;
        @(negedge clk);
        chk("idle_ready", req_ready, 0);
        chk("idle_resp", resp_valid, 0);
        chk("idle_mreq", mem_req, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < int'(N); i++) begin
            addr_v[i] = '0;
            data_v[i] = '0;
        end
        #2;
        check_all_zero("rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        rr_m  = 0;

        // Single write from requester 1, immediate grant
        addr_v[1] = 16'h0010;
        data_v[1] = 32'hDEAD_BEEF;
        run_txn(3'b010, 3'b010, 0, 0, '0, 1'b0);
        idle_check();

        // Read from requester 0 answered after several wait cycles
        addr_v[0] = 16'h0020;
        run_txn(3'b001, 3'b000, 0, 3, 32'h1234_5678, 1'b0);

        // Bring rr pointer back to 0, then all three hold reads continuously
        addr_v[2] = 16'h0300;
        data_v[2] = 32'hCAFE_0002;
        run_txn(3'b100, 3'b100, 1, 0, '0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(N); i++) addr_v[i] = AW'($urandom);
            run_txn(3'b111, 3'b000, 0, r % 3, DW'($urandom), 1'b0);
        end
        idle_check();

        // Timeout with no rvalid, stray rvalid afterwards, then rvalid on the timeout cycle
        run_txn(3'b001, 3'b000, 0, 10, 32'hFFFF_FFFF, 1'b0);
        idle_check();
        run_txn(3'b001, 3'b000, 0, int'(TMO) - 1, 32'hA5A5_5A5A, 1'b0);

        // Long stall in ISSUE with other requesters toggling
        addr_v[1] = 16'hBEEF;
        data_v[1] = 32'h0BAD_F00D;
        run_txn(3'b010, 3'b010, 10, 0, '0, 1'b1);
        idle_check();

        // Reset during an outstanding read aborts it
        addr_v[0] = 16'h0444;
        drive_payload(3'b001, 3'b000);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold_resp", resp_valid, 0);
            @(posedge clk); #1;
        end
        req_valid = '0;
        reset     = 1'b0;
        rr_m      = 0;
        addr_v[2] = 16'h2222;
        run_txn(3'b100, 3'b000, 0, 1, 32'h2222_2222, 1'b0);

        // Random transactions
        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] vm;
            vm = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < int'(N); i++) begin
                addr_v[i] = AW'($urandom);
                data_v[i] = DW'($urandom);
            end
            run_txn(vm, N'($urandom), $urandom_range(0, 3), $urandom_range(0, 6),
                    DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
